// File: rtl/alu_req_arbiter.sv
// Two-requester front end for a shared 8-bit ALU: credit-limited round-robin issue,
// a tag pipeline that follows the fixed ALU latency, and per-requester in-order response FIFOs.
module alu_req_arbiter #(
  parameter int ALU_LAT = 3,
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [1:0]  req_s,
  input  logic [3:0]  req_s1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_s,
  output logic [1:0]  alu_s1,
  input  logic [15:0] alu_out,
  output logic        busy
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);

  logic [CW-1:0] r_cnt [2];
  logic [CW-1:0] r_fcnt [2];
  logic [PW-1:0] r_wr [2];
  logic [PW-1:0] r_rd [2];
  logic [15:0]   r_mem [2][MAX_OUT];
  logic          r_last;
  logic [ALU_LAT:0] r_tagV;
  logic [ALU_LAT:0] r_tagId;

  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic       w_accept;
  logic       w_win;
  logic [1:0] w_push;
  logic [1:0] w_pop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_elig  = '0;
    w_grant = '0;
    for (int i = 0; i < 2; i++) begin
      w_elig[i] = req_valid[i] && (r_cnt[i] < MAXC);
    end
    if (reset) begin
      if (&w_elig) begin
        w_grant = r_last ? 2'b01 : 2'b10;
      end else begin
        w_grant = w_elig;
      end
    end
    w_accept  = |w_grant;
    w_win     = w_grant[1];
    req_ready = w_grant;
  end

  always_comb begin
    w_push[0] = r_tagV[ALU_LAT] & ~r_tagId[ALU_LAT];
    w_push[1] = r_tagV[ALU_LAT] &  r_tagId[ALU_LAT];
    for (int i = 0; i < 2; i++) begin
      rsp_valid[i] = (r_fcnt[i] != '0);
    end
    w_pop = rsp_valid & rsp_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_s   <= 1'b0;
      alu_s1  <= '0;
      r_last  <= 1'b1;
      r_tagV  <= '0;
      r_tagId <= '0;
    end else begin
      if (w_accept) begin
        alu_a  <= w_win ? req_a[15:8]  : req_a[7:0];
        alu_b  <= w_win ? req_b[15:8]  : req_b[7:0];
        alu_s  <= w_win ? req_s[1]     : req_s[0];
        alu_s1 <= w_win ? req_s1[3:2]  : req_s1[1:0];
        r_last <= w_win;
      end
      r_tagV  <= {r_tagV[ALU_LAT-1:0], w_accept};
      r_tagId <= {r_tagId[ALU_LAT-1:0], w_win};
    end
  end

  // Credits cover in-flight ops as well as queued results, so a push never finds a full FIFO.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i]  <= '0;
        r_fcnt[i] <= '0;
        r_wr[i]   <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        case ({w_grant[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: ;
        endcase
        case ({w_push[i], w_pop[i]})
          2'b10:   r_fcnt[i] <= r_fcnt[i] + 1'b1;
          2'b01:   r_fcnt[i] <= r_fcnt[i] - 1'b1;
          default: ;
        endcase
        if (w_push[i]) r_wr[i] <= nextPtr(r_wr[i]);
        if (w_pop[i])  r_rd[i] <= nextPtr(r_rd[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset && w_push[i]) begin
        r_mem[i][r_wr[i]] <= alu_out;
      end
    end
  end

  assign rsp_data = {r_mem[1][r_rd[1]], r_mem[0][r_rd[0]]};
  assign busy     = (r_cnt[0] != '0) || (r_cnt[1] != '0);

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Front-end scheduler that shares the single 8-bit ALU (arithmetic/logic selector with registered 16-bit result) between two requesters. Accepts operations over valid/ready handshakes, arbitrates round-robin under per-requester credit limits, and drives the ALU operand and select lines. It tracks each issued op through the fixed ALU latency with a tag pipeline and returns each result, in order, to the requester that issued it through per-requester response FIFOs.

## Interface
- ALU_LAT, 3: cycles from ALU inputs stable to the matching result on alu_out.
- MAX_OUT, 2: maximum ops in flight plus queued responses per requester; also the response FIFO depth (≥1).

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; sampled on clk rising edge.
- req_valid  in  2  bit i: requester i presents an op.
- req_ready  out  2  bit i: op accepted this cycle (combinational).
- req_a, req_b  in  16  operands, {req1, req0} packed, 8 bits each.
- req_s  in  2  per-requester arithmetic/logic select.
- req_s1  in  4  per-requester 2-bit op code, packed.
- rsp_valid  out  2  bit i: result available for requester i.
- rsp_ready  in  2  bit i: requester i takes the result.
- rsp_data  out  32  {rsp1, rsp0}, 16 bits each; FIFO head.
- alu_a, alu_b  out  8  registered ALU operands.
- alu_s  out  1  registered select.
- alu_s1  out  2  registered op code.
- alu_out  in  16  ALU result.
- busy  out  1  any credit counter non-zero.

## Operation
- Credit counter cnt[i] (0..MAX_OUT) counts ops accepted and not yet popped.
  - +1 on accept, −1 on rsp pop, unchanged when both occur together.
- Eligibility: eligible[i] = req_valid[i] && cnt[i] < MAX_OUT.
- Round-robin arbitration, one grant per cycle:
  - Pointer last holds the most recent granted index and resets to 1, so requester 0 wins the first tie.
  - One eligible requester: it wins.
  - Both eligible: grant the index != last.
  - last updates only on a grant.
- req_ready = one-hot grant. Forced 0 while reset is low.
- On accept: load alu_a/alu_b/alu_s/alu_s1 from the winner's fields. Otherwise they hold their value.
- Tag pipeline of ALU_LAT+1 stages carries {valid, id}.
  - Stage 0 is loaded with {accept, winner} on accept, {0, x} otherwise.
  - When the last stage is valid, push alu_out into FIFO[id] at that cycle's edge.
- Response FIFOs:
  - In order, depth MAX_OUT.
  - Cannot overflow, because credits include in-flight ops.
  - No bypass: a push into an empty FIFO makes rsp_valid rise the following cycle.
  - Push and pop in the same cycle are both honoured.
- rsp_valid[i] = FIFO[i] non-empty. rsp_data holds the head stably until popped.
- Results are never reordered or lost. ALU outputs with no valid tag are ignored.

## Timing
- Accept at cycle T:
  - alu_* stable from T+1.
  - Result on alu_out in T+1+ALU_LAT and captured at the end of that cycle.
  - rsp_valid high from T+2+ALU_LAT. Default: 5 cycles after accept.
- Sustained throughput is one op per cycle in total, provided credits are available.
- Reset (reset low at an edge) gives, the next cycle:
  - cnt, tags, FIFOs and rsp_valid = 0; last = 1.
  - alu_a/alu_b/alu_s/alu_s1 = 0; busy = 0.
- Reset mid-operation discards all in-flight and queued results. ALU data arriving after reset is dropped because the tags are cleared.
- Requesters must hold req fields stable while req_valid is high and not accepted.

## Test plan
Benches use an ALU stub: alu_out = {alu_a, alu_b} delayed ALU_LAT cycles.
- Single op:
  - Stimulus: req0 a=8'h12, b=8'h34, rsp_ready=1.
  - Response: accepted at T; alu_a=8'h12 at T+1; rsp_valid[0] at T+5 with rsp0=16'h1234; cnt returns to 0; busy falls.
- Contention:
  - Stimulus: both valid continuously, unlimited rsp_ready.
  - Response: grants 0,1,0,1…; each requester receives its own {a,b} in issue order.
- Credit exhaustion:
  - Stimulus: req0 valid with rsp_ready[0]=0, MAX_OUT=2.
  - Response: exactly 2 accepts, then req_ready[0]=0 indefinitely; req1 is still served.
  - Pop one result: exactly one further accept.
- Simultaneous pop and accept at cnt=MAX_OUT−1:
  - Response: cnt unchanged; a FIFO push and a pop in the same cycle preserve order and data.
- Reset mid-flight:
  - Stimulus: 3 ops in flight; reset low one cycle.
  - Response: the next cycle has all outputs at reset values; no rsp_valid for the discarded ops; a fresh op then completes in 5 cycles.
